// File: rtl/icache_if.sv
// Burst RAM command and read-data bus between icache (master) and burst_ram (slave).
interface icache_if #(
    parameter int RAM_DEPTH_BITWIDTH      = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64
);
    logic                                   br_cmd;
    logic                                   br_cmd_en;
    logic [RAM_DEPTH_BITWIDTH-1:0]          br_addr;
    logic [RAM_BURST_DATA_BITWIDTH-1:0]     br_wr_data;
    logic [RAM_BURST_DATA_BITWIDTH/8-1:0]   br_data_mask;
    logic [RAM_BURST_DATA_BITWIDTH-1:0]     br_rd_data;
    logic                                   br_rd_data_valid;
    logic                                   br_busy;

    modport master (
        output br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
        input  br_rd_data, br_rd_data_valid, br_busy
    );

    modport slave (
        input  br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
        output br_rd_data, br_rd_data_valid, br_busy
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache; a miss refills a whole line
// with one RAM read burst and returns the requested word as soon as it lands.
module icache #(
    parameter int LINE_IX_BITWIDTH                = 1,
    parameter int ADDRESS_BITWIDTH                = 32,
    parameter int INSTRUCTION_BITWIDTH            = 32,
    parameter int INSTRUCTION_IX_IN_LINE_BITWIDTH = 3,
    parameter int RAM_DEPTH_BITWIDTH              = 4,
    parameter int RAM_BURST_DATA_BITWIDTH         = 64,
    parameter int RAM_BURST_DATA_COUNT            = 4
) (
    input  logic                            clk,
    input  logic                            clk_ram,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [ADDRESS_BITWIDTH-1:0]     address,
    output logic [INSTRUCTION_BITWIDTH-1:0] instruction,
    output logic                            data_ready,
    output logic                            busy,
    icache_if.master                        br
);
    localparam int LINES    = 1 << LINE_IX_BITWIDTH;
    localparam int IXW      = INSTRUCTION_IX_IN_LINE_BITWIDTH;
    localparam int IPL      = 1 << IXW;
    localparam int IB_OFF   = $clog2(INSTRUCTION_BITWIDTH / 8);
    localparam int LINE_OFF = IB_OFF + IXW;
    localparam int TAG_LSB  = LINE_OFF + LINE_IX_BITWIDTH;
    localparam int TAG_W    = ADDRESS_BITWIDTH - TAG_LSB;
    localparam int IPW      = RAM_BURST_DATA_BITWIDTH / INSTRUCTION_BITWIDTH;
    localparam int WORD_OFF = $clog2(RAM_BURST_DATA_BITWIDTH / 8);
    localparam int CNT_W    = $clog2(RAM_BURST_DATA_COUNT);

    typedef enum logic [1:0] {IDLE, ISSUE, FILL} state_t;

    state_t state, state_next;

    logic [ADDRESS_BITWIDTH-1:0]     addr_q;
    logic [LINES-1:0]                valid;
    logic [TAG_W-1:0]                tags  [LINES];
    logic [INSTRUCTION_BITWIDTH-1:0] lines [LINES][IPL];
    logic [CNT_W-1:0]                word_cnt;
    logic [31:0]                     stat_cache_hits;
    logic [31:0]                     stat_cache_misses;

    logic [LINE_IX_BITWIDTH-1:0] req_line, q_line;
    logic [TAG_W-1:0]            req_tag, q_tag;
    logic [IXW-1:0]              req_ix, q_ix;
    logic                        hit, accept, fill_beat, last_word;
    logic                        unused_bits;

    assign req_line = address[LINE_OFF +: LINE_IX_BITWIDTH];
    assign req_tag  = address[ADDRESS_BITWIDTH-1:TAG_LSB];
    assign req_ix   = address[IB_OFF +: IXW];
    assign q_line   = addr_q[LINE_OFF +: LINE_IX_BITWIDTH];
    assign q_tag    = addr_q[ADDRESS_BITWIDTH-1:TAG_LSB];
    assign q_ix     = addr_q[IB_OFF +: IXW];

    assign hit       = valid[req_line] && (tags[req_line] == req_tag);
    assign accept    = enable && (state == IDLE);
    assign fill_beat = (state == FILL) && br.br_rd_data_valid;
    assign last_word = fill_beat &&
                       (word_cnt == CNT_W'(RAM_BURST_DATA_COUNT - 1));

    assign busy             = (state != IDLE);
    assign br.br_cmd        = 1'b0;
    assign br.br_wr_data    = '0;
    assign br.br_data_mask  = '0;
    // Burst starts at the line-aligned byte address expressed in RAM words.
    assign br.br_addr = {addr_q[WORD_OFF+RAM_DEPTH_BITWIDTH-1:LINE_OFF],
                         {(LINE_OFF-WORD_OFF){1'b0}}};

    assign unused_bits = ^{clk_ram, addr_q[IB_OFF-1:0]};

    always_comb begin
        state_next   = state;
        br.br_cmd_en = 1'b0;
        unique case (state)
            IDLE:  if (accept && !hit) state_next = ISSUE;
            ISSUE: begin
                if (!br.br_busy) begin
                    br.br_cmd_en = 1'b1;
                    state_next   = FILL;
                end
            end
            FILL:  if (last_word) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            addr_q            <= '0;
            valid             <= '0;
            word_cnt          <= '0;
            instruction       <= '0;
            data_ready        <= 1'b0;
            stat_cache_hits   <= '0;
            stat_cache_misses <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q   <= address;
                word_cnt <= '0;
                if (hit) begin
                    stat_cache_hits <= stat_cache_hits + 32'd1;
                    instruction     <= lines[req_line][req_ix];
                    data_ready      <= 1'b1;
                end else begin
                    stat_cache_misses <= stat_cache_misses + 32'd1;
                    valid[req_line]   <= 1'b0;
                    data_ready        <= 1'b0;
                end
            end
            if (fill_beat) begin
                word_cnt <= word_cnt + 1'b1;
                // Hand the requested word to fetch without waiting for the burst end.
                if (word_cnt == CNT_W'(int'(q_ix) / IPW)) begin
                    instruction <= br.br_rd_data[(int'(q_ix) % IPW) *
                                   INSTRUCTION_BITWIDTH +: INSTRUCTION_BITWIDTH];
                    data_ready  <= 1'b1;
                end
                if (last_word) valid[q_line] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_beat) begin
            for (int i = 0; i < IPW; i++) begin
                lines[q_line][IXW'(int'(word_cnt) * IPW + i)] <=
                    br.br_rd_data[i*INSTRUCTION_BITWIDTH +: INSTRUCTION_BITWIDTH];
            end
            if (last_word) tags[q_line] <= q_tag;
        end
    end
endmodule

// File: tb/tb_icache.sv
// Randomized bench for icache: burst RAM model plus a line-level reference
// model of the cache contents, hit/miss counters and burst timing.
module tb_icache;
    localparam int LAT = 3;
    localparam int BC  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] address;
    logic [31:0] instruction;
    logic        data_ready;
    logic        busy;

    icache_if br ();

    icache dut (
        .clk(clk), .clk_ram(clk), .rst(rst), .enable(enable),
        .address(address), .instruction(instruction),
        .data_ready(data_ready), .busy(busy), .br(br)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model
    logic [63:0] ram [16];
    logic        acc_evt = 1'b0;
    logic [3:0]  acc_addr = '0;
    int          cmd_pulses = 0;
    bit          ram_act = 0;
    int          ram_cnt = 0;
    logic [3:0]  ram_base = '0;
    int          word_cyc [BC];

    always @(posedge clk) begin
        acc_evt <= br.br_cmd_en && !br.br_busy;
        if (br.br_cmd_en && !br.br_busy) acc_addr <= br.br_addr;
        if (br.br_cmd_en) cmd_pulses <= cmd_pulses + 1;
    end

    initial begin
        br.br_busy          = 1'b0;
        br.br_rd_data_valid = 1'b0;
        br.br_rd_data       = '0;
        forever begin
            @(negedge clk);
            br.br_rd_data_valid = 1'b0;
            br.br_rd_data       = {$urandom, $urandom};
            if (ram_act) begin
                ram_cnt++;
                if (ram_cnt >= LAT && ram_cnt < LAT + BC) begin
                    br.br_rd_data_valid = 1'b1;
                    br.br_rd_data = ram[4'(int'(ram_base) + ram_cnt - LAT)];
                    word_cyc[ram_cnt-LAT] = cyc;
                end
                if (ram_cnt == LAT + BC) begin
                    ram_act    = 0;
                    br.br_busy = ($urandom_range(0, 3) == 0);
                end
            end else if (acc_evt) begin
                ram_act    = 1;
                ram_cnt    = 1;
                ram_base   = acc_addr;
                br.br_busy = 1'b1;
            end else begin
                br.br_busy = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Reference model
    bit          m_valid [2];
    logic [25:0] m_tag   [2];
    int          m_hits   = 0;
    int          m_misses = 0;

    function automatic logic [31:0] m_instr(input logic [31:0] a);
        logic [63:0] w;
        w = ram[(a / 8) % 16];
        return ((a / 4) % 2 == 1) ? w[63:32] : w[31:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [31:0] a, input bit poke);
        int          line;
        logic [25:0] tag;
        bit          hit;
        int          c0;
        int          k;
        int          wi;
        line = int'((a / 32) % 2);
        tag  = 26'(a / 64);
        hit  = m_valid[line] && (m_tag[line] == tag);
        wi   = int'((a / 4) % 8) / 2;
        @(negedge clk);
        c0      = cmd_pulses;
        enable  = 1'b1;
        address = a;
        @(negedge clk);
        enable  = 1'b0;
        address = $urandom;
        if (hit) begin
            m_hits++;
            check("hit_ready", data_ready, 1);
            check("hit_instr", instruction, m_instr(a));
            check("hit_busy", busy, 0);
        end else begin
            m_misses++;
            m_valid[line] = 0;
            check("miss_busy", busy, 1);
            check("miss_ready_clr", data_ready, 0);
            if (poke) begin
                enable  = 1'b1;
                address = $urandom;
                @(negedge clk);
                enable  = 1'b0;
            end
            k = 0;
            while (!data_ready && k < 60) begin
                @(negedge clk);
                k++;
            end
            check("miss_ready", data_ready, 1);
            check("miss_instr", instruction, m_instr(a));
            check("early_ready_cyc", cyc, word_cyc[wi] + 1);
            while (busy && k < 80) begin
                @(negedge clk);
                k++;
            end
            check("fill_done", busy, 0);
            check("busy_fall_cyc", cyc, word_cyc[BC-1] + 1);
            check("cmd_addr", acc_addr, ((a / 32) % 4) * 4);
            check("ready_hold", data_ready, 1);
            check("instr_hold", instruction, m_instr(a));
            m_valid[line] = 1;
            m_tag[line]   = tag;
        end
        check("cmd_count", cmd_pulses - c0, hit ? 0 : 1);
        check("stat_hits", dut.stat_cache_hits, m_hits);
        check("stat_misses", dut.stat_cache_misses, m_misses);
    endtask

    task automatic check_reset_outputs();
        check("rst_instr", instruction, 0);
        check("rst_ready", data_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_en", br.br_cmd_en, 0);
        check("rst_cmd", br.br_cmd, 0);
        check("rst_addr", br.br_addr, 0);
        check("rst_wr_data", br.br_wr_data, 0);
        check("rst_mask", br.br_data_mask, 0);
        check("rst_hits", dut.stat_cache_hits, 0);
        check("rst_misses", dut.stat_cache_misses, 0);
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 16; i++) ram[i] = {$urandom, $urandom};
        ram[0]        = 64'h3F5A2E14_B7C6A980;
        ram[1][31:0]  = 32'hAB4C3E6F;
        ram[2][31:0]  = 32'hD5B8A9C4;
        ram[4][31:0]  = 32'h2F5E3C7A;
        ram[8][63:32] = 32'h0A1B2C3D;

        rst     = 1'b1;
        enable  = 1'b0;
        address = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        do_req(32'd0, 0);
        check("plan_a0", instruction, 32'hB7C6A980);
        check("plan_m1", dut.stat_cache_misses, 1);
        do_req(32'd4, 0);
        check("plan_a4", instruction, 32'h3F5A2E14);
        check("plan_h1", dut.stat_cache_hits, 1);
        do_req(32'd8, 0);
        check("plan_a8", instruction, 32'hAB4C3E6F);
        do_req(32'd16, 0);
        check("plan_a16", instruction, 32'hD5B8A9C4);
        check("plan_h3", dut.stat_cache_hits, 3);
        do_req(32'd32, 1);
        check("plan_a32", instruction, 32'h2F5E3C7A);
        check("plan_m2", dut.stat_cache_misses, 2);
        do_req(32'd68, 0);
        check("plan_a68", instruction, 32'h0A1B2C3D);
        check("plan_m3", dut.stat_cache_misses, 3);
        do_req(32'd0, 0);
        check("plan_m4", dut.stat_cache_misses, 4);

        for (int i = 0; i < 150; i++) begin
            a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) |
                $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) a = a | ($urandom << 8);
            do_req(a, ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of a refill drops every line.
        @(negedge clk);
        enable  = 1'b1;
        address = 32'h0000_0040;
        if (m_valid[0] && m_tag[0] == 26'd1) address = 32'h0000_0080;
        @(negedge clk);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs();
        m_valid[0] = 0;
        m_valid[1] = 0;
        m_hits     = 0;
        m_misses   = 0;
        do_req(32'd0, 0);
        do_req(32'd36, 0);
        do_req(32'd4, 0);
        check("post_rst_hits", dut.stat_cache_hits, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
